uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
// - Shares the SoC's single UART transmit serializer between two byte requesters:
//   req0 = CPU UART peripheral writes, req1 = hardware RX echo path.
// - Sequences the serializer start/busy handshake and arbitrates round-robin.
// - Supports message locking so multi-byte strings (e.g. "45/42=") are not
//   interleaved with echo bytes.
// PARAMETERS
// - IDLE_GAP      default 0     extra clk cycles inserted after each frame completes
// - HOLD_TIMEOUT  default 4096  clk cycles a locked owner may stall before the lock drops
// PORTS
// - clk         in   1  system clock, rising edge
// - resetn      in   1  asynchronous, active-low reset
// - req0_valid  in   1  requester 0 has a byte
// - req0_data   in   8  requester 0 byte
// - req0_last   in   1  byte ends requester 0 message (releases lock)
// - req0_ready  out  1  requester 0 byte accepted this cycle (valid&&ready)
// - req1_valid, req1_data[7:0], req1_last, req1_ready: same roles for requester 1
// - tx_start    out  1  one-cycle start pulse to serializer
// - tx_data     out  8  byte to serializer, stable from tx_start until busy falls
// - tx_busy     in   1  serializer busy; rises <=2 cycles after tx_start
// - grant       out  2  one-hot current owner; 0 when no owner
// - locked      out  1  an owner holds the lock between bytes of a message
// BEHAVIOUR
// - Reset: state=IDLE; tx_start, tx_data, reqN_ready, grant, locked all 0; rr pointer = req0.
// - reqN_ready is combinational: state in {IDLE, HOLD}, tx_busy=0, N selected.
//   At most one ready is high in any cycle.
// - IDLE: if any valid and !tx_busy, select winner.
//   - Both valid: winner is the requester not granted last (rr pointer).
//   - Accept on that edge: tx_data<=data; grant<=winner; locked<=!last; go START.
// - START: tx_start=1 for exactly one cycle; go WAIT.
// - WAIT: set seen_busy when tx_busy=1. After seen_busy, tx_busy=0 ends the frame.
//   - If tx_busy never rises within 2 cycles of START, the frame is treated as done.
//   - Next state: GAP if IDLE_GAP>0, else the post-frame state.
// - GAP: count IDLE_GAP cycles, then go to the post-frame state.
// - Post-frame: HOLD if locked, else IDLE. On entering IDLE: grant<=0; rr pointer
//   moves to the other requester.
// - HOLD: only the owner is eligible. The other requester's ready stays 0.
//   - Owner valid: accept as in IDLE, timer cleared.
//   - Timer reaches HOLD_TIMEOUT: locked<=0, grant<=0, go IDLE.
// - Throughput: with IDLE_GAP=0, one accepted byte per frame.
//   Accept-to-tx_start latency is 1 cycle.
// - reqN_valid dropping without acceptance has no effect.
//   data/last are sampled only at acceptance.
// - tx_busy high in IDLE/HOLD (external owner) blocks acceptance; no error.
// - Reset mid-frame: outputs return to reset values immediately.
//   The serializer finishes its frame independently; the arbiter restarts in IDLE.
// CONFIGURATION
// - UART_ARB_CRLF_EN defined:
//   - An accepted byte 8'h0A is sent as two frames: 8'h0D, then 8'h0A.
//   - IDLE_GAP applies between the two frames. Grant and lock are held across both.
//   - No ready is asserted until the 8'h0A frame completes.
//   - A last flag on the 8'h0A takes effect after the second frame.
// - UART_ARB_CRLF_EN undefined: 8'h0A is sent unmodified as a single frame.
// TESTING
// - Model the serializer as busy for 10 cycles, rising 1 cycle after tx_start.
// - Single req0 0x34 last=1 -> tx_start pulse 1 cycle after ready; tx_data=0x34;
//   grant=01 during frame, then 00; locked=0.
// - req0 and req1 both valid from reset -> req0 (0x34) is sent first, then req1 (0x35).
//   Repeat -> req1 wins first. Round-robin alternates.
// - req0 sends 0x34,0x35,0x2F,0x34,0x32 with last only on 0x32, req1 valid throughout
//   -> all five req0 bytes are sent contiguously, req1_ready=0 until 0x32 completes.
// - Lock held, req0 silent for HOLD_TIMEOUT=16 cycles -> locked=0 at cycle 16;
//   the pending req1 byte is then accepted.
// - Assert resetn=0 during WAIT -> all outputs 0 asynchronously.
//   After release, a new req1 0x39 is sent normally.
// - UART_ARB_CRLF_EN: req1 sends 0x0A -> two frames, tx_data 0x0D then 0x0A;
//   req1_ready stays 0 until the second frame ends. Macro undefined -> one 0x0A frame.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Byte handshake bundle between two requesters, the UART transmit arbiter and the serializer.
interface uart_tx_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_last;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_last;
    logic       req1_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic [1:0] grant;
    logic       locked;

    modport slave (
        input  req0_valid, req0_data, req0_last,
        input  req1_valid, req1_data, req1_last,
        input  tx_busy,
        output req0_ready, req1_ready,
        output tx_start, tx_data, grant, locked
    );

    modport master (
        output req0_valid, req0_data, req0_last,
        output req1_valid, req1_data, req1_last,
        output tx_busy,
        input  req0_ready, req1_ready,
        input  tx_start, tx_data, grant, locked
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locking arbiter sharing one UART serializer between two byte requesters.
// Optional CR/LF expansion of 8'h0A is enabled by defining UART_ARB_CRLF_EN.
module uart_tx_arbiter #(
    parameter int IDLE_GAP     = 0,
    parameter int HOLD_TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             resetn,
    uart_tx_arbiter_if.slave bus
);
    localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam int HW = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
    localparam logic [GW-1:0] GAP_LAST  = GW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_GAP,
        S_HOLD
    } state_t;

    state_t        state, state_n;
    logic [7:0]    tx_data_q, tx_data_n;
    logic [1:0]    grant_q, grant_n;
    logic          locked_q, locked_n;
    logic          rr_q, rr_n;
    logic          seen_busy_q, seen_busy_n;
    logic [1:0]    wait_cnt_q, wait_cnt_n;
    logic [GW-1:0] gap_cnt_q, gap_cnt_n;
    logic [HW-1:0] hold_cnt_q, hold_cnt_n;
    logic          crlf_pending_q, crlf_pending_n;

    logic          sel;
    logic          eligible;
    logic [7:0]    sel_data;
    logic          sel_last;
    logic          post_frame;

    // In HOLD only the lock owner may win; in IDLE a tie goes to the rr pointer.
    always_comb begin
        sel      = 1'b0;
        eligible = 1'b0;
        if (state == S_IDLE) begin
            sel      = (bus.req0_valid && bus.req1_valid) ? rr_q : bus.req1_valid;
            eligible = (bus.req0_valid || bus.req1_valid) && !bus.tx_busy;
        end else if (state == S_HOLD) begin
            sel      = grant_q[1];
            eligible = (grant_q[1] ? bus.req1_valid : bus.req0_valid) && !bus.tx_busy;
        end
        sel_data = sel ? bus.req1_data : bus.req0_data;
        sel_last = sel ? bus.req1_last : bus.req0_last;
    end

    assign bus.req0_ready = resetn && eligible && !sel;
    assign bus.req1_ready = resetn && eligible && sel;
    assign bus.tx_start   = (state == S_START);
    assign bus.tx_data    = tx_data_q;
    assign bus.grant      = grant_q;
    assign bus.locked     = locked_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= S_IDLE;
            tx_data_q      <= 8'h00;
            grant_q        <= 2'b00;
            locked_q       <= 1'b0;
            rr_q           <= 1'b0;
            seen_busy_q    <= 1'b0;
            wait_cnt_q     <= 2'd0;
            gap_cnt_q      <= '0;
            hold_cnt_q     <= '0;
            crlf_pending_q <= 1'b0;
        end else begin
            state          <= state_n;
            tx_data_q      <= tx_data_n;
            grant_q        <= grant_n;
            locked_q       <= locked_n;
            rr_q           <= rr_n;
            seen_busy_q    <= seen_busy_n;
            wait_cnt_q     <= wait_cnt_n;
            gap_cnt_q      <= gap_cnt_n;
            hold_cnt_q     <= hold_cnt_n;
            crlf_pending_q <= crlf_pending_n;
        end
    end

    always_comb begin
        state_n        = state;
        tx_data_n      = tx_data_q;
        grant_n        = grant_q;
        locked_n       = locked_q;
        rr_n           = rr_q;
        seen_busy_n    = seen_busy_q;
        wait_cnt_n     = wait_cnt_q;
        gap_cnt_n      = gap_cnt_q;
        hold_cnt_n     = hold_cnt_q;
        crlf_pending_n = crlf_pending_q;
        post_frame     = 1'b0;

        case (state)
            S_IDLE, S_HOLD: begin
                if (eligible) begin
                    state_n    = S_START;
                    tx_data_n  = sel_data;
                    grant_n    = sel ? 2'b10 : 2'b01;
                    locked_n   = !sel_last;
                    hold_cnt_n = '0;
`ifdef UART_ARB_CRLF_EN
                    if (sel_data == 8'h0A) begin
                        tx_data_n      = 8'h0D;
                        crlf_pending_n = 1'b1;
                    end
`endif
                end else if (state == S_HOLD) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_n  = S_IDLE;
                        locked_n = 1'b0;
                        grant_n  = 2'b00;
                        rr_n     = !grant_q[1];
                    end else begin
                        hold_cnt_n = hold_cnt_q + 1'b1;
                    end
                end
            end
            S_START: begin
                state_n     = S_WAIT;
                seen_busy_n = 1'b0;
                wait_cnt_n  = 2'd0;
            end
            // A serializer that never raises busy within two cycles is treated as done.
            S_WAIT: begin
                if (bus.tx_busy) begin
                    seen_busy_n = 1'b1;
                end else if (seen_busy_q || (wait_cnt_q == 2'd2)) begin
                    if (IDLE_GAP > 0) begin
                        state_n   = S_GAP;
                        gap_cnt_n = '0;
                    end else begin
                        post_frame = 1'b1;
                    end
                end
                if (!seen_busy_q && (wait_cnt_q != 2'd2)) begin
                    wait_cnt_n = wait_cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    post_frame = 1'b1;
                end else begin
                    gap_cnt_n = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // The LF half of an expanded newline keeps grant and lock until it has gone out.
        if (post_frame) begin
            if (crlf_pending_q) begin
                tx_data_n      = 8'h0A;
                crlf_pending_n = 1'b0;
                state_n        = S_START;
            end else if (locked_q) begin
                state_n    = S_HOLD;
                hold_cnt_n = '0;
            end else begin
                state_n = S_IDLE;
                grant_n = 2'b00;
                rr_n    = !grant_q[1];
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a 10-cycle serializer model and a frame log.
module tb_uart_tx_arbiter;
    logic       clk    = 1'b0;
    logic       resetn = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         busy_cnt = 0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [9:0] frames[$];

    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(
        .IDLE_GAP     (0),
        .HOLD_TIMEOUT (16)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Serializer: busy for 10 cycles starting the cycle after tx_start; ignores arbiter reset.
    assign bus.tx_busy = (busy_cnt != 0);
    always @(posedge clk) begin
        if (bus.tx_start && busy_cnt == 0) busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        if (bus.tx_start) frames.push_back({bus.grant, bus.tx_data});
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int req, input logic valid, input logic [7:0] data, input logic last);
        if (req == 0) begin
            bus.req0_valid = valid;
            bus.req0_data  = data;
            bus.req0_last  = last;
        end else begin
            bus.req1_valid = valid;
            bus.req1_data  = data;
            bus.req1_last  = last;
        end
    endtask

    task automatic do_reset();
        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1, 1'b0, 8'h00, 1'b0);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        frames.delete();
    endtask

    // Drive both queues until they drain and the arbiter is idle for three cycles.
    task automatic pump(input string tag);
        int   idle_run;
        int   cyc;
        logic both_ready;
        idle_run   = 0;
        cyc        = 0;
        both_ready = 1'b0;
        while (idle_run < 3 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (q0.size() != 0) applyStimulus(0, 1'b1, q0[0][7:0], q0[0][8]);
            else applyStimulus(0, 1'b0, 8'h00, 1'b0);
            if (q1.size() != 0) applyStimulus(1, 1'b1, q1[0][7:0], q1[0][8]);
            else applyStimulus(1, 1'b0, 8'h00, 1'b0);
            #1;
            if (bus.req0_ready && bus.req1_ready) both_ready = 1'b1;
            if (bus.req0_valid && bus.req0_ready) void'(q0.pop_front());
            if (bus.req1_valid && bus.req1_ready) void'(q1.pop_front());
            if (q0.size() == 0 && q1.size() == 0 && bus.grant == 2'b00 && !bus.locked && !bus.tx_busy)
                idle_run++;
            else
                idle_run = 0;
        end
        checkOutput({tag, "_timeout"}, 32'(cyc >= 2000), 32'h0);
        checkOutput({tag, "_both_ready"}, 32'(both_ready), 32'h0);
    endtask

    task automatic wait_busy(input string tag, input logic level);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.tx_busy !== level && n < 40);
        checkOutput({tag, "_busy_wait"}, 32'(bus.tx_busy), 32'(level));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        applyStimulus(0, 1'b1, 8'h34, 1'b1);
        applyStimulus(1, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("rst_tx_start", 32'(bus.tx_start), 32'h0);
        checkOutput("rst_tx_data",  32'(bus.tx_data),  32'h0);
        checkOutput("rst_grant",    32'(bus.grant),    32'h0);
        checkOutput("rst_locked",   32'(bus.locked),   32'h0);
        checkOutput("rst_ready0",   32'(bus.req0_ready), 32'h0);
        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        resetn = 1'b1;
        frames.delete();

        // Single byte from req0
        @(negedge clk);
        applyStimulus(0, 1'b1, 8'h34, 1'b1);
        #1;
        checkOutput("t1_ready0", 32'(bus.req0_ready), 32'h1);
        checkOutput("t1_ready1", 32'(bus.req1_ready), 32'h0);
        checkOutput("t1_no_start_yet", 32'(bus.tx_start), 32'h0);
        @(negedge clk);
        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        checkOutput("t1_start", 32'(bus.tx_start), 32'h1);
        checkOutput("t1_data",  32'(bus.tx_data),  32'h34);
        checkOutput("t1_grant", 32'(bus.grant),    32'h1);
        checkOutput("t1_locked", 32'(bus.locked),  32'h0);
        @(negedge clk);
        checkOutput("t1_start_one_cycle", 32'(bus.tx_start), 32'h0);
        checkOutput("t1_grant_frame", 32'(bus.grant), 32'h1);
        pump("t1");
        checkOutput("t1_grant_end", 32'(bus.grant), 32'h0);
        checkOutput("t1_nframes", 32'(frames.size()), 32'h1);
        checkOutput("t1_frame0", 32'(frames[0]), 32'h134);

        // rr pointer now favours req1
        frames.delete();
        q0.push_back(9'h134);
        q1.push_back(9'h135);
        pump("t2");
        checkOutput("t2_nframes", 32'(frames.size()), 32'h2);
        checkOutput("t2_frame0", 32'(frames[0]), 32'h235);
        checkOutput("t2_frame1", 32'(frames[1]), 32'h134);

        // After reset req0 wins first and the grant alternates
        do_reset();
        q0.push_back(9'h134); q0.push_back(9'h136);
        q1.push_back(9'h135); q1.push_back(9'h137);
        pump("t3");
        checkOutput("t3_nframes", 32'(frames.size()), 32'h4);
        checkOutput("t3_frame0", 32'(frames[0]), 32'h134);
        checkOutput("t3_frame1", 32'(frames[1]), 32'h235);
        checkOutput("t3_frame2", 32'(frames[2]), 32'h136);
        checkOutput("t3_frame3", 32'(frames[3]), 32'h237);

        // Locked message "45/42" is not interleaved with req1
        do_reset();
        q0.push_back(9'h034); q0.push_back(9'h035); q0.push_back(9'h02F);
        q0.push_back(9'h034); q0.push_back(9'h132);
        q1.push_back(9'h141);
        pump("t4");
        checkOutput("t4_nframes", 32'(frames.size()), 32'h6);
        checkOutput("t4_frame0", 32'(frames[0]), 32'h134);
        checkOutput("t4_frame1", 32'(frames[1]), 32'h135);
        checkOutput("t4_frame2", 32'(frames[2]), 32'h12F);
        checkOutput("t4_frame3", 32'(frames[3]), 32'h134);
        checkOutput("t4_frame4", 32'(frames[4]), 32'h132);
        checkOutput("t4_frame5", 32'(frames[5]), 32'h241);

        // Lock timeout after 16 stalled HOLD cycles
        do_reset();
        @(negedge clk);
        applyStimulus(0, 1'b1, 8'h34, 1'b0);
        #1;
        checkOutput("t5_ready0", 32'(bus.req0_ready), 32'h1);
        @(negedge clk);
        applyStimulus(0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1, 1'b1, 8'h39, 1'b1);
        checkOutput("t5_locked_start", 32'(bus.locked), 32'h1);
        wait_busy("t5_rise", 1'b1);
        wait_busy("t5_fall", 1'b0);
        @(negedge clk);
        checkOutput("t5_hold_locked", 32'(bus.locked), 32'h1);
        checkOutput("t5_hold_grant",  32'(bus.grant),  32'h1);
        checkOutput("t5_hold_ready1", 32'(bus.req1_ready), 32'h0);
        repeat (15) @(negedge clk);
        checkOutput("t5_locked_c15", 32'(bus.locked), 32'h1);
        @(negedge clk);
        checkOutput("t5_locked_c16", 32'(bus.locked), 32'h0);
        checkOutput("t5_grant_c16",  32'(bus.grant),  32'h0);
        checkOutput("t5_ready1_c16", 32'(bus.req1_ready), 32'h1);
        @(negedge clk);
        applyStimulus(1, 1'b0, 8'h00, 1'b0);
        checkOutput("t5_start", 32'(bus.tx_start), 32'h1);
        checkOutput("t5_data",  32'(bus.tx_data),  32'h39);
        checkOutput("t5_grant", 32'(bus.grant),    32'h2);
        pump("t5");
        checkOutput("t5_nframes", 32'(frames.size()), 32'h2);

        // Reset during WAIT clears outputs at once; the next byte still goes out
        do_reset();
        @(negedge clk);
        applyStimulus(1, 1'b1, 8'h37, 1'b0);
        @(negedge clk);
        applyStimulus(1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("t6_pre_locked", 32'(bus.locked), 32'h1);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("t6_rst_grant",   32'(bus.grant),    32'h0);
        checkOutput("t6_rst_locked",  32'(bus.locked),   32'h0);
        checkOutput("t6_rst_data",    32'(bus.tx_data),  32'h0);
        checkOutput("t6_rst_start",   32'(bus.tx_start), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        frames.delete();
        applyStimulus(1, 1'b1, 8'h39, 1'b1);
        #1;
        checkOutput("t6_busy_blocks", 32'(bus.req1_ready), 32'h0);
        q1.push_back(9'h139);
        pump("t6");
        checkOutput("t6_nframes", 32'(frames.size()), 32'h1);
        checkOutput("t6_frame0", 32'(frames[0]), 32'h239);

        // Newline handling
        do_reset();
        q1.push_back(9'h00A);
        q1.push_back(9'h142);
        pump("t7");
`ifdef UART_ARB_CRLF_EN
        checkOutput("t7_nframes", 32'(frames.size()), 32'h3);
        checkOutput("t7_frame0", 32'(frames[0]), 32'h20D);
        checkOutput("t7_frame1", 32'(frames[1]), 32'h20A);
        checkOutput("t7_frame2", 32'(frames[2]), 32'h242);
`else
        checkOutput("t7_nframes", 32'(frames.size()), 32'h2);
        checkOutput("t7_frame0", 32'(frames[0]), 32'h20A);
        checkOutput("t7_frame1", 32'(frames[1]), 32'h242);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
